// File: rtl/psram_qspi_engine.sv
// ----------------------------------------------------------------------------
// psram_qspi_engine
// Serial protocol engine for the PSRAM controller. Takes one transfer at a
// time from the AHB-Lite wrapper (read 0xEB / write 0x38, 24-bit address,
// 1..4 bytes) and generates the QSPI pin sequence.
//
// Ports:
//   HCLK, HRESETn          clock, async active-low reset
//   start, rd_wr, addr,    transfer request and its attributes, sampled
//   size, wdata            together while idle
//   rdata                  packed read data, first byte in [7:0]
//   busy, done             transfer in flight / one-cycle completion pulse
//   sck, ce_n              serial clock (HCLK/2) and chip enable
//   din, dout, douten      quad data pins
//
// state | meaning
// IDLE  | pins parked, waiting for start
// CMD   | 8 command bits on dout[0], MSB first
// ADDR  | 6 address nibbles, high nibble first
// WAIT  | dummy cycles before read data, bus released
// DATA  | 2 nibbles per byte, high nibble first
// DONE  | ce_n high, done pulse
// ----------------------------------------------------------------------------
module psram_qspi_engine #(
    parameter int unsigned WAIT_CYCLES = 6
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic        rd_wr,
    input  logic [23:0] addr,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        sck,
    output logic        ce_n,
    input  logic [3:0]  din,
    output logic [3:0]  dout,
    output logic [3:0]  douten
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WAIT, S_DATA, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] k_q, k_d;
    logic        rd_q, rd_d;
    logic [23:0] addr_q, addr_d;
    logic [2:0]  n_q, n_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic [7:0]  cmd;
    logic [4:0]  aoff;
    logic [4:0]  doff;
    logic [15:0] data_last;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            n_q     <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            n_q     <= n_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q + 16'd1;
        rd_d      = rd_q;
        addr_d    = addr_q;
        n_d       = n_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ce_n      = 1'b1;
        sck       = 1'b0;
        dout      = 4'b0000;
        douten    = 4'b0000;
        busy      = 1'b1;
        done      = 1'b0;

        cmd       = rd_q ? 8'hEB : 8'h38;
        // Address nibble a (0..5) sits at bit 20-4a; k[3:1] is the nibble index.
        aoff      = 5'd20 - {k_q[3:1], 2'b00};
        // Data nibble: byte k[4:2], high nibble while k[1]=0.
        doff      = {k_q[4:2], ~k_q[1], 2'b00};
        data_last = {11'd0, n_q, 2'b00} - 16'd1;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                k_d  = '0;
                if (start) begin
                    rd_d    = rd_wr;
                    addr_d  = addr;
                    wdata_d = wdata;
                    n_d     = (size >= 3'd1 && size <= 3'd4) ? size : 3'd4;
                    if (rd_wr) rdata_d = '0;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                ce_n    = 1'b0;
                sck     = k_q[0];
                douten  = 4'b1111;
                dout[0] = cmd[~k_q[3:1]];
                if (k_q == 16'd15) begin
                    k_d     = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                ce_n   = 1'b0;
                sck    = k_q[0];
                douten = 4'b1111;
                dout   = addr_q[aoff +: 4];
                if (k_q == 16'd11) begin
                    k_d     = '0;
                    state_d = (rd_q && WAIT_CYCLES != 0) ? S_WAIT : S_DATA;
                end
            end
            S_WAIT: begin
                ce_n = 1'b0;
                sck  = k_q[0];
                if (k_q == 16'(2 * WAIT_CYCLES - 1)) begin
                    k_d     = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                ce_n = 1'b0;
                sck  = k_q[0];
                if (rd_q) begin
                    // Sample on the edge that ends the sck-high phase.
                    if (k_q[0]) rdata_d[doff +: 4] = din;
                end else begin
                    douten = 4'b1111;
                    dout   = wdata_q[doff +: 4];
                end
                if (k_q == data_last) begin
                    k_d     = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                k_d     = '0;
                state_d = S_IDLE;
            end
            default: begin
                k_d     = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_psram_qspi_engine.sv
module tb_psram_qspi_engine;

    localparam int W = 6;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic        rd_wr;
    logic [23:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy, done, sck, ce_n;
    logic [3:0]  din, dout, douten;

    psram_qspi_engine #(.WAIT_CYCLES(W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .rd_wr(rd_wr),
        .addr(addr), .size(size), .wdata(wdata), .rdata(rdata),
        .busy(busy), .done(done), .sck(sck), .ce_n(ce_n),
        .din(din), .dout(dout), .douten(douten)
    );

    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_mis = 0;

    // PSRAM memory image (what the device holds)
    logic [7:0] mem [int];

    // Current transfer as seen by the reference model
    logic        tx_rd;
    logic [23:0] tx_addr;
    int          tx_n;
    logic [31:0] tx_wdata;
    int          tx_len;
    logic [31:0] prev_rdata;

    function automatic logic [7:0] get_byte(logic [23:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 8'h00;
    endfunction

    // Byte value moved in data position b of the current transfer.
    function automatic logic [7:0] tx_byte(int b);
        logic [7:0] v;
        if (tx_rd) v = get_byte(tx_addr + 24'(b));
        else       v = tx_wdata[8*b +: 8];
        return v;
    endfunction

    // Expected {ce_n, sck, dout, douten, done, busy} in cycle T0+c.
    function automatic logic [11:0] exp_pins(int c);
        int p, d, j;
        logic [7:0] cmd, byt;
        logic ce, sc, dn, bz;
        logic [3:0] dq, oe;
        ce = 1; sc = 0; dq = 0; oe = 0; dn = 0; bz = 0;
        if (c >= 1 && c <= tx_len) begin
            ce = 0; bz = 1; p = c - 1; sc = p[0];
            if (p < 16) begin
                cmd = tx_rd ? 8'hEB : 8'h38;
                dq  = {3'b000, cmd[7 - p/2]};
                oe  = 4'hF;
            end else if (p < 28) begin
                dq = tx_addr[23 - 4*((p-16)/2) -: 4];
                oe = 4'hF;
            end else if (tx_rd && p < 28 + 2*W) begin
                dq = 0;
            end else begin
                d   = p - 28 - (tx_rd ? 2*W : 0);
                j   = d / 2;
                byt = tx_byte(j / 2);
                if (!tx_rd) begin
                    dq = (j % 2 == 0) ? byt[7:4] : byt[3:0];
                    oe = 4'hF;
                end
            end
        end else if (c == tx_len + 1) begin
            dn = 1; bz = 1;
        end
        return {ce, sc, dq, oe, dn, bz};
    endfunction

    // Nibble the device drives on din during cycle T0+c of a read.
    function automatic logic [3:0] dev_nib(int c);
        int d, j;
        logic [7:0] byt;
        d = c - 1 - 28 - 2*W;
        if (!tx_rd || d < 0 || c > tx_len) return 4'h0;
        j   = d / 2;
        byt = tx_byte(j / 2);
        return (j % 2 == 0) ? byt[7:4] : byt[3:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setup_tx(input bit rd, input logic [23:0] a, input logic [2:0] sz,
                            input logic [31:0] wd);
        tx_rd    = rd;
        tx_addr  = a;
        tx_n     = (sz >= 1 && sz <= 4) ? int'(sz) : 4;
        tx_wdata = wd;
        tx_len   = 28 + (rd ? 2*W : 0) + 4*tx_n;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // cycle after done, so a following call tests back-to-back accept.
    task automatic run_xfer(input bit rd, input logic [23:0] a, input logic [2:0] sz,
                            input logic [31:0] wd, input bit inject);
        logic [31:0] exp_rd;
        int dones;
        setup_tx(rd, a, sz, wd);
        exp_rd = prev_rdata;
        if (rd) begin
            exp_rd = '0;
            for (int i = 0; i < tx_n; i++) exp_rd[8*i +: 8] = get_byte(a + 24'(i));
        end
        start = 1; rd_wr = rd; addr = a; size = sz; wdata = wd;
        @(negedge HCLK);
        start = 0;
        dones = 0;
        for (int c = 1; c <= tx_len + 2; c++) begin
            check("pins", {20'd0, ce_n, sck, dout, douten, done, busy}, {20'd0, exp_pins(c)});
            if (done) dones++;
            if (rd && c == tx_len + 1) check("rdata_at_done", rdata, exp_rd);
            din = dev_nib(c);
            if (inject && c == 20) begin
                start = 1; addr = a ^ 24'h5A5A5A; rd_wr = ~rd; size = 3'd1;
                wdata = ~wd;
            end
            if (inject && c == 21) start = 0;
            if (c < tx_len + 2) @(negedge HCLK);
        end
        check("done_count", dones, 1);
        check("rdata_after", rdata, exp_rd);
        if (!rd)
            for (int i = 0; i < tx_n; i++) mem[int'(a + 24'(i))] = wd[8*i +: 8];
        prev_rdata = exp_rd;
    endtask

    initial begin
        HRESETn = 0; start = 0; rd_wr = 0; addr = 0; size = 0; wdata = 0; din = 0;
        prev_rdata = 0;
        repeat (5) @(negedge HCLK);
        check("reset_pins", {26'd0, ce_n, sck, busy, done}, {26'd0, 4'b1000});
        check("reset_dout", {24'd0, dout, douten}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        HRESETn = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            check("idle_pins", {30'd0, ce_n, sck}, 32'd2);
        end

        run_xfer(0, 24'h000000, 3'd4, 32'hABCD1234, 0);
        run_xfer(1, 24'h000000, 3'd4, 32'h0, 0);
        check("read_word", rdata, 32'hABCD1234);
        run_xfer(1, 24'h000002, 3'd1, 32'h0, 0);
        check("read_byte", rdata, 32'h000000CD);
        run_xfer(0, 24'h000010, 3'd2, 32'h00009988, 1);
        run_xfer(1, 24'h00000F, 3'd4, 32'h0, 1);
        @(negedge HCLK);

        // Reset in the middle of read data.
        setup_tx(1, 24'h000000, 3'd4, 32'h0);
        start = 1; rd_wr = 1; addr = 0; size = 4;
        @(negedge HCLK);
        start = 0;
        for (int c = 1; c <= 28 + 2*W + 5; c++) begin
            din = dev_nib(c);
            @(negedge HCLK);
        end
        #1 HRESETn = 0;
        #1;
        check("midrst_pins", {26'd0, ce_n, sck, busy, done}, {26'd0, 4'b1000});
        check("midrst_oe", {24'd0, dout, douten}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            check("midrst_nodone", {31'd0, done}, 32'd0);
        end
        HRESETn = 1;
        prev_rdata = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            check("postrst_idle", {29'd0, ce_n, sck, done}, 32'd4);
        end

        run_xfer(0, 24'd100, 3'd4, 32'h88776655, 0);
        run_xfer(1, 24'd100, 3'd4, 32'h0, 0);
        check("readback", rdata, 32'h88776655);

        for (int t = 0; t < 30; t++) begin
            logic [23:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 24'hFFFFFC + 24'($urandom_range(0, 3))
                                             : 24'($urandom_range(0, 23));
            run_xfer(1'($urandom_range(0, 1)), ra, 3'($urandom_range(0, 7)), $urandom,
                     1'($urandom_range(0, 4) == 0));
        end

        @(negedge HCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/psram_qspi_engine.md
# psram_qspi_engine

Serial protocol engine for the PSRAM controller. The AHB-Lite front end hands it one transfer at a time: read or write, 24-bit byte address, 1–4 bytes. The engine generates the QSPI pin sequence (sck, ce_n, dout/douten, din sampling), returns packed read data and pulses `done`. It is the stage directly downstream of the AHB-Lite wrapper and drives the PSRAM device pins.

## Interface
Parameters:
- `WAIT_CYCLES`, default 6: dummy sck cycles between address and data on reads (0xEB).

Ports:
- `HCLK`  in  1  single clock; all logic on rising edge.
- `HRESETn`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request; accepted only when `busy`=0.
- `rd_wr`  in  1  1 = read (cmd 0xEB), 0 = write (cmd 0x38); sampled with `start`.
- `addr`  in  24  byte address; sampled with `start`.
- `size`  in  3  byte count 1..4; 0 and 5..7 treated as 4; sampled with `start`.
- `wdata`  in  32  write data; byte0 = [7:0], sent first; sampled with `start`.
- `rdata`  out  32  read data, first byte received in [7:0]; unreceived bytes 0.
- `busy`  out  1  high from cycle after accept until `done` cycle inclusive.
- `done`  out  1  one-cycle completion pulse.
- `sck`  out  1  serial clock, HCLK/2 while ce_n low.
- `ce_n`  out  1  chip enable, active low.
- `din`  in  4  sampled data from pins.
- `dout`  out  4  driven data.
- `douten`  out  4  output enables, 1 = drive.

## Operation
- States: IDLE → CMD → ADDR → (WAIT, read only) → DATA → DONE → IDLE.
- In IDLE, `start`=1 latches `rd_wr`, `addr`, `size` and `wdata`, then moves to CMD. While `busy`, `start` is ignored: inputs are not latched and not queued.
- Each sck period is 2 HCLK. A phase counter `k` restarts at 0 on every state entry, and sck = k[0].
- `dout` changes only at the start of a sck-low phase and is held for 2 HCLK.
- CMD, 16 HCLK: 8 bits, MSB first, on `dout[0]`; `dout[3:1]`=0.
- ADDR, 12 HCLK: 6 nibbles, `addr[23:20]` first, on `dout[3:0]`.
- WAIT, 2·WAIT_CYCLES HCLK: `douten`=0, `dout`=0.
- DATA, 4·N HCLK (N = effective size):
  - Write: bytes in ascending order, high nibble of each byte first.
  - Read: `din` is sampled on the HCLK edge ending each sck-high phase (sck 1→0), high nibble first, and shifted into byte slot i of `rdata`.
- `douten` = 4'b1111 in CMD, ADDR and write DATA; 4'b0000 in IDLE, WAIT, read DATA and DONE.
- DONE, 1 HCLK: ce_n=1, sck=0, `done`=1, `busy`=1.
- `rdata` is cleared at accept of a read and holds after `done` until the next accepted read. Writes leave `rdata` unchanged.
- Reset, including mid-transfer, takes effect asynchronously:
  - state IDLE; ce_n=1, sck=0;
  - dout=0, douten=0;
  - rdata=0, busy=0, done=0.
- No partial-transfer completion is signalled after reset.

## Timing
- Reset values: ce_n=1, sck=0, dout=0, douten=0, rdata=0, busy=0, done=0.
- `start` accepted at edge T0. From cycle T0+1: ce_n=0, busy=1, first CMD bit on `dout[0]`, sck=0.
- ce_n low duration:
  - Write: 16+12+4N HCLK.
  - Read: 16+12+2·WAIT_CYCLES+4N HCLK.
- `done` is asserted in the first cycle with ce_n=1. `busy` falls the cycle after.
- Earliest next accept: the cycle after `done`, so ce_n is high for at least 2 HCLK between transfers.
- Read, N=4, WAIT_CYCLES=6: ce_n low for 56 HCLK; `done` at T0+57; `rdata` valid in that cycle.
- Write, N=4: ce_n low for 44 HCLK; `done` at T0+45.

## Test plan
- Reset: hold HRESETn=0 for 5 cycles → all outputs at reset values. Release, no start → ce_n stays 1 and sck stays 0.
- Write word: addr=0, wdata=0xABCD1234, size=4 → pins show cmd bits 0x38, address nibbles 000000, data nibbles 3,4,1,2,C,D,A,B; `done` at T0+45.
- Read word: addr=0 against the PSRAM VIP holding the previous write → rdata=0xABCD1234; `done` at T0+57; douten=0 from WAIT onward.
- Read byte: addr=2, size=1 → rdata=0x000000CD; ce_n low for 44 HCLK.
- `start` pulsed mid-transfer with a different addr → ignored; the first transfer completes unchanged and there is exactly one `done` pulse.
- HRESETn asserted during DATA of a read → ce_n=1, sck=0 and douten=0 immediately; no `done`. A subsequent write of 0x88776655 to addr 100 followed by a read back returns 0x88776655.
